// File: rtl/ccff_multi_chain_loader.sv
// Sequenced configuration-chain loader: prog reset, parallel shift of NUM_CHAINS chains, hand-off to user mode.
// Optional tail check of shifted-out bits is enabled by defining CCFF_TAIL_CHECK_EN.
module ccff_multi_chain_loader #(
    parameter int NUM_CHAINS   = 8,
    parameter int CHAIN_LEN    = 1024,
    parameter int RESET_CYCLES = 4
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  ccff_shift_en,
    output logic                  fabric_prog_reset,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CHAINS-1:0] tail_err
);

    localparam int CNT_MAX = (CHAIN_LEN > RESET_CYCLES) ? CHAIN_LEN : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CHAINS-1:0]   head_d;
    logic                    shift_en_d;
    logic                    prog_reset_d;
    logic                    cfg_en_d;
    logic                    busy_d;
    logic                    done_d;
    logic [NUM_CHAINS-1:0]   tail_err_d;
    logic [NUM_CHAINS-1:0]   tail_sample;

`ifdef CCFF_TAIL_CHECK_EN
    // Chains were cleared by fabric_prog_reset, so every bit shifted out during a load must be 0.
    assign tail_sample = (ccff_shift_en && busy) ? ccff_tail : '0;
`else
    logic unused_tail;
    assign tail_sample = '0;
    assign unused_tail = ^ccff_tail;
`endif

    assign bs_ready = (state_q == S_SHIFT);

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        head_d       = ccff_head;
        shift_en_d   = 1'b0;
        prog_reset_d = 1'b0;
        cfg_en_d     = config_enable;
        busy_d       = busy;
        done_d       = done;
        tail_err_d   = tail_err | tail_sample;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RST;
                    cnt_d        = CNT_W'(RESET_CYCLES - 1);
                    prog_reset_d = 1'b1;
                    cfg_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    tail_err_d   = '0;
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                end else begin
                    cnt_d        = cnt_q - CNT_W'(1);
                    prog_reset_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bs_valid) begin
                    head_d     = bs_data;
                    shift_en_d = 1'b1;
                    // The final beat leaves the counter parked at CHAIN_LEN-1 instead of wrapping.
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                state_d  = S_DONE;
                head_d   = '0;
                cfg_en_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                cnt_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            ccff_head         <= '0;
            ccff_shift_en     <= 1'b0;
            fabric_prog_reset <= 1'b0;
            config_enable     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            tail_err          <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            ccff_head         <= head_d;
            ccff_shift_en     <= shift_en_d;
            fabric_prog_reset <= prog_reset_d;
            config_enable     <= cfg_en_d;
            busy              <= busy_d;
            done              <= done_d;
            tail_err          <= tail_err_d;
        end
    end

endmodule

// File: tb/tb_ccff_multi_chain_loader.sv
// Scoreboard bench for ccff_multi_chain_loader with a behavioural two-chain fabric model.
module tb_ccff_multi_chain_loader;

    localparam int NC = 2;
    localparam int CL = 4;
    localparam int RC = 2;

    logic          prog_clk = 1'b0;
    logic          prog_reset_n;
    logic          start;
    logic [NC-1:0] bs_data;
    logic          bs_valid;
    logic          bs_ready;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          ccff_shift_en;
    logic          fabric_prog_reset;
    logic          config_enable;
    logic          busy;
    logic          done;
    logic [NC-1:0] tail_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [NC-1:0] exp_q[$];
    logic [NC-1:0] beats[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [CL-1:0] chain[NC];
    logic [NC-1:0] last_head = '0;
    logic          prev_pr = 1'b0;
    int            rst_run = 0;
    int            rst_pulses = 0;
    int            pulse_cnt = 0;
    logic          inject = 1'b0;

`ifdef CCFF_TAIL_CHECK_EN
    localparam logic [NC-1:0] INJ_TAIL_EXP = 2'b10;
`else
    localparam logic [NC-1:0] INJ_TAIL_EXP = 2'b00;
`endif

    ccff_multi_chain_loader #(
        .NUM_CHAINS  (NC),
        .CHAIN_LEN   (CL),
        .RESET_CYCLES(RC)
    ) dut (
        .prog_clk         (prog_clk),
        .prog_reset_n     (prog_reset_n),
        .start            (start),
        .bs_data          (bs_data),
        .bs_valid         (bs_valid),
        .bs_ready         (bs_ready),
        .ccff_head        (ccff_head),
        .ccff_tail        (ccff_tail),
        .ccff_shift_en    (ccff_shift_en),
        .fabric_prog_reset(fabric_prog_reset),
        .config_enable    (config_enable),
        .busy             (busy),
        .done             (done),
        .tail_err         (tail_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fabric model: cleared by prog reset, shifts head-first; bit 0 is nearest the head.
    always @(posedge prog_clk) begin
        for (int i = 0; i < NC; i++) begin
            if (fabric_prog_reset) chain[i] <= '0;
            else if (ccff_shift_en) chain[i] <= {chain[i][CL-2:0], ccff_head[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < NC; i++) ccff_tail[i] = chain[i][CL-1];
        if (inject && ccff_shift_en && pulse_cnt == 3) ccff_tail[1] = 1'b1;
    end

    // Monitor: pops the scoreboard on every shift pulse and tracks prog-reset pulse length.
    always @(negedge prog_clk) begin
        if (prog_reset_n) begin
            if (ccff_shift_en) begin
                if (exp_q.size() == 0) check("unexpected_shift", 32'd1, 32'd0);
                else check("shift_head", 32'(ccff_head), 32'(exp_q.pop_front()));
                pulse_cnt++;
            end else if (config_enable && !fabric_prog_reset) begin
                check("head_hold", 32'(ccff_head), 32'(last_head));
            end
            last_head = ccff_head;
            if (fabric_prog_reset) begin
                if (!prev_pr) rst_pulses++;
                rst_run++;
            end else if (prev_pr) begin
                check("prog_reset_len", rst_run, RC);
                rst_run = 0;
            end
            prev_pr = fabric_prog_reset;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_head"},     32'(ccff_head), 0);
        check({tag, "_shift_en"}, 32'(ccff_shift_en), 0);
        check({tag, "_prog_rst"}, 32'(fabric_prog_reset), 0);
        check({tag, "_cfg_en"},   32'(config_enable), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_tail_err"}, 32'(tail_err), 0);
        check({tag, "_ready"},    32'(bs_ready), 0);
    endtask

    task automatic run_load(input logic [6:0] vpat, input int plen, input bit start_mid,
                            input int abort_after, input logic [NC-1:0] exp_tail);
        int k = 0;
        int n = 0;
        int cyc = 0;
        int first_ready = -1;
        pulse_cnt  = 0;
        rst_pulses = 0;
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done_clr", 32'(done), 0);
        check("start_prog_reset", 32'(fabric_prog_reset), 1);
        check("start_cfg_en", 32'(config_enable), 1);
        check("start_tail_clr", 32'(tail_err), 0);
        while (n < CL && cyc < 100) begin
            if (bs_ready) begin
                if (first_ready < 0) first_ready = cyc;
                bs_valid = vpat[k % plen];
                k++;
            end else begin
                bs_valid = 1'b1;
            end
            bs_data = beats[n];
            start   = start_mid && (n == 2);
            @(negedge prog_clk);
            if (bs_valid && bs_ready) begin
                exp_q.push_back(bs_data);
                n++;
            end
            if (abort_after > 0 && n == abort_after) begin
                @(posedge prog_clk); #1 prog_reset_n = 1'b0;
                #1 check_all_zero("midreset");
                exp_q.delete();
                start    = 1'b0;
                bs_valid = 1'b0;
                repeat (2) @(posedge prog_clk);
                @(negedge prog_clk) prog_reset_n = 1'b1;
                prev_pr = 1'b0;
                rst_run = 0;
                return;
            end
            @(posedge prog_clk); #1;
            cyc++;
        end
        start    = 1'b0;
        bs_valid = 1'b0;
        check("load_beats", n, CL);
        check("first_ready_lat", first_ready, RC);
        check("flush_ready", 32'(bs_ready), 0);
        check("flush_shift_en", 32'(ccff_shift_en), 1);
        check("flush_done", 32'(done), 0);
        check("flush_busy", 32'(busy), 1);
        @(posedge prog_clk); #1;
        check("done_set", 32'(done), 1);
        check("done_cfg_en", 32'(config_enable), 0);
        check("done_busy", 32'(busy), 0);
        check("done_head", 32'(ccff_head), 0);
        check("done_shift_en", 32'(ccff_shift_en), 0);
        check("done_tail_err", 32'(tail_err), 32'(exp_tail));
        repeat (3) @(posedge prog_clk);
        #1;
        check("done_sticky", 32'(done), 1);
        check("done_idle_busy", 32'(busy), 0);
        check("shift_pulses", pulse_cnt, CL);
        check("scoreboard_empty", exp_q.size(), 0);
        check("prog_reset_pulses", rst_pulses, 1);
        check("chain0", 32'(chain[0]), 32'(4'b1010));
        check("chain1", 32'(chain[1]), 32'(4'b0110));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog_reset_n = 1'b1;
        start        = 1'b0;
        bs_valid     = 1'b0;
        bs_data      = '0;
        #2 prog_reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;

        // bs_valid in IDLE must not be accepted.
        @(posedge prog_clk); #1 bs_valid = 1'b1; bs_data = 2'b11;
        @(negedge prog_clk);
        check("idle_ready", 32'(bs_ready), 0);
        @(posedge prog_clk); #1;
        check("idle_shift_en", 32'(ccff_shift_en), 0);
        check("idle_busy", 32'(busy), 0);
        bs_valid = 1'b0;

        run_load(7'b1111111, 1, 1'b0, 0, 2'b00);        // basic
        run_load(7'b1011001, 7, 1'b0, 0, 2'b00);        // backpressure 1,0,0,1,1,0,1 (restart from DONE)
        run_load(7'b1111111, 1, 1'b1, 0, 2'b00);        // start ignored during SHIFT
        run_load(7'b1111111, 1, 1'b0, 2, 2'b00);        // reset after beat 2
        run_load(7'b1111111, 1, 1'b0, 0, 2'b00);        // full load after reset
        inject = 1'b1;
        run_load(7'b1111111, 1, 1'b0, 0, INJ_TAIL_EXP); // tail fault on 3rd pulse
        inject = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
